sp_ram_arbiter: RTL

Shares one single-port RAM (registered-output configuration, 1-cycle read latency, gated by enable) among NUM_REQS requesters using round-robin arbitration with a valid/ready handshake. It also runs a built-in clear sequencer that writes INIT_VALUE to every word after reset or on request. Read responses go through a 2-entry response FIFO on a shared, tag-carrying response channel. The block sits directly in front of the RAM instance; requesters never drive the RAM directly.

---
 rtl/sp_ram_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sp_ram_arbiter.sv
// Round-robin front end for one single-port RAM: N requesters, clear sequencer,
// and a 2-entry tagged read-response FIFO.
`timescale 1ns/1ps
module sp_ram_arbiter #(
    parameter int               NUM_REQS    = 4,
    parameter int               DATAW       = 32,
    parameter int               SIZE        = 256,
    parameter int               ADDRW       = $clog2(SIZE),
    parameter int               BYTEENW     = DATAW / 8,
    parameter int               TAGW        = 4,
    parameter bit               INIT_ENABLE = 1'b1,
    parameter logic [DATAW-1:0] INIT_VALUE  = '0,
    parameter int               REQW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS-1:0]       req_rw,
    input  logic [NUM_REQS*ADDRW-1:0] req_addr,
    input  logic [NUM_REQS*BYTEENW-1:0] req_byteen,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS*TAGW-1:0]  req_tag,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      rsp_valid,
    output logic [REQW-1:0]           rsp_idx,
    output logic [TAGW-1:0]           rsp_tag,
    output logic [DATAW-1:0]          rsp_data,
    input  logic                      rsp_ready,
    input  logic                      clear,
    output logic                      init_done,
    output logic                      ram_en,
    output logic [BYTEENW-1:0]        ram_wren,
    output logic [ADDRW-1:0]          ram_addr,
    output logic [DATAW-1:0]          ram_wdata,
    input  logic [DATAW-1:0]          ram_rdata
);

    typedef enum logic [1:0] {ST_INIT, ST_DRAIN, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDRW-1:0]  clr_addr_q, clr_addr_d;
    logic [REQW-1:0]   rr_q, rr_d;
    logic              infl_q;
    logic [REQW-1:0]   infl_idx_q;
    logic [TAGW-1:0]   infl_tag_q;
    logic [DATAW-1:0]  fifo_data_q [2];
    logic [REQW-1:0]   fifo_idx_q  [2];
    logic [TAGW-1:0]   fifo_tag_q  [2];
    logic              fifo_wp_q, fifo_rp_q;
    logic [1:0]        fifo_cnt_q;

    logic              win_found;
    int                win_i;
    logic [REQW-1:0]   win_idx;
    logic              win_rw;
    logic [TAGW-1:0]   win_tag;
    logic              pop;
    logic              rd_ok;
    logic              grant;

    // Winner: first valid requester at or after the round-robin pointer
    always_comb begin
        win_found = 1'b0;
        win_i     = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!win_found && req_valid[(int'(rr_q) + i) % NUM_REQS]) begin
                win_found = 1'b1;
                win_i     = (int'(rr_q) + i) % NUM_REQS;
            end
        end
    end

    assign win_idx = REQW'(win_i);
    assign win_rw  = req_rw[win_i];
    assign win_tag = req_tag[win_i*TAGW +: TAGW];

    assign pop   = (fifo_cnt_q != 2'd0) && rsp_ready;
    // In-flight read plus queued responses, minus the one leaving now, must leave room
    assign rd_ok = ({1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rr_d       = rr_q;
        grant      = 1'b0;
        req_ready  = '0;
        ram_en     = 1'b0;
        ram_wren   = '0;
        ram_addr   = '0;
        ram_wdata  = '0;
        unique case (state_q)
            ST_INIT: begin
                ram_en     = 1'b1;
                ram_wren   = '1;
                ram_addr   = clr_addr_q;
                ram_wdata  = INIT_VALUE;
                clr_addr_d = clr_addr_q + ADDRW'(1);
                if (clr_addr_q == ADDRW'(SIZE - 1)) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!infl_q) begin
                    state_d    = ST_INIT;
                    clr_addr_d = '0;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_DRAIN;
                end else if (win_found && (win_rw || rd_ok)) begin
                    grant            = 1'b1;
                    req_ready[win_i] = 1'b1;
                    ram_en           = 1'b1;
                    ram_addr         = req_addr[win_i*ADDRW +: ADDRW];
                    if (win_rw) begin
                        ram_wren  = req_byteen[win_i*BYTEENW +: BYTEENW];
                        ram_wdata = req_data[win_i*DATAW +: DATAW];
                    end
                    rr_d = (win_i == NUM_REQS - 1) ? '0 : REQW'(win_i + 1);
                end
            end
            default: state_d = ST_INIT;
        endcase
        // Keep every output quiet while reset is held, whatever the reset state
        if (!reset_n) begin
            grant     = 1'b0;
            req_ready = '0;
            ram_en    = 1'b0;
            ram_wren  = '0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT_ENABLE ? ST_INIT : ST_RUN;
            clr_addr_q <= '0;
            rr_q       <= '0;
            infl_q     <= 1'b0;
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rr_q       <= rr_d;
            infl_q     <= grant && !win_rw;
            if (infl_q) fifo_wp_q <= ~fifo_wp_q;
            if (pop)    fifo_rp_q <= ~fifo_rp_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

    // RAM data lands one cycle after the read grant and is queued with its idx/tag
    always_ff @(posedge clk) begin
        if (grant && !win_rw) begin
            infl_idx_q <= win_idx;
            infl_tag_q <= win_tag;
        end
        if (infl_q) begin
            fifo_data_q[fifo_wp_q] <= ram_rdata;
            fifo_idx_q[fifo_wp_q]  <= infl_idx_q;
            fifo_tag_q[fifo_wp_q]  <= infl_tag_q;
        end
    end

    assign rsp_valid = (fifo_cnt_q != 2'd0);
    assign rsp_idx   = rsp_valid ? fifo_idx_q[fifo_rp_q]  : '0;
    assign rsp_tag   = rsp_valid ? fifo_tag_q[fifo_rp_q]  : '0;
    assign rsp_data  = rsp_valid ? fifo_data_q[fifo_rp_q] : '0;
    assign init_done = (state_q == ST_RUN) && reset_n;

endmodule
